// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 codes,
// result-select encoding, FSM state type and the access legality check.
package mem_stage_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } lsu_state_e;

   // Size/alignment legality of a load or store; unused funct3 codes are illegal.
   function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B, F3_BU: return 1'b1;
         F3_H, F3_HU: return ~off[0];
         F3_W:        return off == 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational data alignment: store lane replication and byte strobes, plus
// load byte/half extraction with sign or zero extension.
module mem_stage_lsu_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] store_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_wstrb,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] load_word,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;
   logic [15:0] ld_half;

   assign ld_shift = load_word >> {ld_off, 3'b000};
   assign ld_half  = ld_off[1] ? load_word[31:16] : load_word[15:0];

   // Store side: size is carried in funct3[1:0] (00 byte, 01 half, else word).
   always_comb begin
      st_wdata = store_data;
      st_wstrb = 4'b1111;
      case (st_funct3[1:0])
         2'b00: begin
            st_wdata = {4{store_data[7:0]}};
            st_wstrb = 4'b0001 << st_off;
         end
         2'b01: begin
            st_wdata = {2{store_data[15:0]}};
            st_wstrb = 4'b0011 << st_off;
         end
         default: ;
      endcase
   end

   // Load side: pick the addressed lane and extend to 32 bits.
   always_comb begin
      ld_data = load_word;
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         F3_BU:   ld_data = {24'h000000, ld_shift[7:0]};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'h0000, ld_half};
         default: ld_data = load_word;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Issues one registered request per access over a
// req/ready port, stalls the pipeline until completion, then releases it for a
// single DONE cycle. Optional bus timeout is compiled in with LSU_TIMEOUT_EN.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [2:0]  Funct3M,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        FaultM,
   output logic        BusErrM
);

   lsu_state_e  state_q, state_d;
   logic        access;
   logic        legal;
   logic        start;
   logic        complete;
   logic        tmo_hit;
   logic [2:0]  ld_f3_q;
   logic [1:0]  ld_off_q;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [31:0] ld_data;

   assign access   = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
   assign legal    = access_legal(Funct3M, ALUResultM[1:0]);
   assign start    = (state_q == StIdle) & access & legal;
   // Ready is only meaningful while a request is outstanding.
   assign complete = (state_q == StBusy) & mem_ready;

   mem_stage_lsu_align u_lsu_align (
      .st_funct3  (Funct3M),
      .st_off     (ALUResultM[1:0]),
      .store_data (WriteDataM),
      .st_wdata   (st_wdata),
      .st_wstrb   (st_wstrb),
      .ld_funct3  (ld_f3_q),
      .ld_off     (ld_off_q),
      .load_word  (mem_rdata),
      .ld_data    (ld_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic; DONE always falls back to IDLE so a held instruction
   // cannot re-issue before the pipeline has advanced.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StBusy;
         StBusy:  if (complete || tmo_hit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Stall output: raised combinationally on a legal access and held while busy.
   always_comb begin
      StallM = start | (state_q == StBusy);
   end

   // Request fields latch at issue and stay stable until the access ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_wstrb <= 4'h0;
         ld_f3_q   <= 3'b000;
         ld_off_q  <= 2'b00;
      end else if (start) begin
         mem_req   <= 1'b1;
         mem_we    <= MemWriteM;
         mem_addr  <= {ALUResultM[31:2], 2'b00};
         mem_wdata <= st_wdata;
         mem_wstrb <= MemWriteM ? st_wstrb : 4'b0000;
         ld_f3_q   <= Funct3M;
         ld_off_q  <= ALUResultM[1:0];
      end else if (complete || tmo_hit) begin
         mem_req   <= 1'b0;
      end
   end

   // Load result register; only a finished load (or a timed-out one) updates it.
   always_ff @(posedge clk) begin
      if (rst)                        ReadDataM <= 32'h0;
      else if (complete && !mem_we)   ReadDataM <= ld_data;
      else if (tmo_hit && !mem_we)    ReadDataM <= 32'h0;
   end

   // Fault pulse for a misaligned or unsupported access seen in IDLE.
   always_ff @(posedge clk) begin
      if (rst) FaultM <= 1'b0;
      else     FaultM <= (state_q == StIdle) & access & ~legal;
   end

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] tmo_cnt_q;

   // Counts BUSY cycles; cnt equals the index of the current BUSY cycle.
   always_ff @(posedge clk) begin
      if (rst || start)              tmo_cnt_q <= '0;
      else if (state_q == StBusy)    tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end

   // A ready arriving on the limit cycle completes normally instead.
   assign tmo_hit = (state_q == StBusy) & ~mem_ready &
                    (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   // Bus error pulse coincides with the DONE cycle of a timed-out access.
   always_ff @(posedge clk) begin
      if (rst) BusErrM <= 1'b0;
      else     BusErrM <= tmo_hit;
   end
`else
   logic unused_timeout;

   assign tmo_hit        = 1'b0;
   assign BusErrM        = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of single accesses with hand-computed
// results, plus sequences for fault pulse width, reset mid-access and timeout.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResultM, WriteDataM, mem_addr, mem_wdata, mem_rdata, ReadDataM;
   logic        MemWriteM, mem_req, mem_we, mem_ready, StallM, FaultM, BusErrM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [3:0]  mem_wstrb;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .Funct3M    (Funct3M),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .FaultM     (FaultM),
      .BusErrM    (BusErrM)
   );

   typedef struct {
      logic        we;
      logic [1:0]  rs;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic        e_fault;
      logic        e_req;
      logic        e_we;
      logic [31:0] e_addr;
      logic [3:0]  e_wstrb;
      logic [31:0] e_wdata;
      int          e_stalls;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      Funct3M    = 3'b000;
      ALUResultM = 32'h0;
      WriteDataM = 32'h0;
      mem_ready  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction, answers after v.waits BUSY cycles, returns at IDLE.
   task automatic do_access(input vec_t v, output int stalls, output logic req,
                            output logic fault, output logic we_o, output logic [31:0] addr_o,
                            output logic [31:0] wdata_o, output logic [3:0] wstrb_o,
                            output logic done_req);
      MemWriteM  = v.we;
      ResultSrcM = v.rs;
      Funct3M    = v.f3;
      ALUResultM = v.addr;
      WriteDataM = v.wdata;
      mem_rdata  = v.rdata;
      mem_ready  = 1'b0;
      #1;
      stalls = StallM ? 1 : 0;
      tick();
      req      = mem_req;
      fault    = FaultM;
      we_o     = mem_we;
      addr_o   = mem_addr;
      wdata_o  = mem_wdata;
      wstrb_o  = mem_wstrb;
      done_req = 1'b0;
      if (req) begin
         for (int i = 0; i < 64 && StallM; i++) begin
            stalls++;
            mem_ready = (i == v.waits);
            tick();
            mem_ready = 1'b0;
         end
         done_req = mem_req;
         clear_inputs();
         tick();
      end else begin
         clear_inputs();
      end
   endtask

   initial begin
      int          st;
      logic        req, fault, we_o, done_req;
      logic [31:0] addr_o, wdata_o;
      logic [3:0]  wstrb_o;

      //            we  rs     f3      addr     wdata         rdata         w  flt req we  e_addr  strb   e_wdata       stl e_rd
      vecs[0]  = '{1'b1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        2, 1'b0, 1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 4, 32'h0};
      vecs[1]  = '{1'b0, 2'b01, 3'b000, 32'h203, 32'h0,        32'h80112233, 0, 1'b0, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0,        2, 32'hFFFFFF80};
      vecs[2]  = '{1'b0, 2'b01, 3'b100, 32'h203, 32'h0,        32'h80112233, 0, 1'b0, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0,        2, 32'h00000080};
      vecs[3]  = '{1'b1, 2'b00, 3'b001, 32'h302, 32'h0000ABCD, 32'h0,        0, 1'b0, 1'b1, 1'b1, 32'h300, 4'hC, 32'hABCDABCD, 2, 32'h00000080};
      vecs[4]  = '{1'b0, 2'b01, 3'b001, 32'h301, 32'h0,        32'h0,        0, 1'b1, 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        0, 32'h00000080};
      vecs[5]  = '{1'b1, 2'b00, 3'b111, 32'h100, 32'h0,        32'h0,        0, 1'b1, 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        0, 32'h00000080};
      vecs[6]  = '{1'b0, 2'b01, 3'b001, 32'h202, 32'h0,        32'h80112233, 1, 1'b0, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0,        3, 32'hFFFF8011};
      vecs[7]  = '{1'b0, 2'b01, 3'b101, 32'h200, 32'h0,        32'h80112233, 0, 1'b0, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0,        2, 32'h00002233};
      vecs[8]  = '{1'b1, 2'b00, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 1'b0, 1'b1, 1'b1, 32'h100, 4'h2, 32'hA5A5A5A5, 2, 32'h00002233};
      vecs[9]  = '{1'b0, 2'b01, 3'b010, 32'h104, 32'h0,        32'h12345678, 0, 1'b0, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0,        2, 32'h12345678};
      vecs[10] = '{1'b0, 2'b01, 3'b010, 32'h106, 32'h0,        32'h0,        0, 1'b1, 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        0, 32'h12345678};
      vecs[11] = '{1'b0, 2'b01, 3'b011, 32'h000, 32'h0,        32'h0,        0, 1'b1, 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        0, 32'h12345678};
      vecs[12] = '{1'b1, 2'b01, 3'b010, 32'h108, 32'h55AA55AA, 32'hFFFFFFFF, 0, 1'b0, 1'b1, 1'b1, 32'h108, 4'hF, 32'h55AA55AA, 2, 32'h12345678};
      vecs[13] = '{1'b0, 2'b10, 3'b010, 32'h110, 32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        0, 32'h12345678};

      clear_inputs();
      mem_rdata = 32'h0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset mem_req",   {31'h0, mem_req}, 32'h0);
      check("reset mem_we",    {31'h0, mem_we},  32'h0);
      check("reset mem_addr",  mem_addr,         32'h0);
      check("reset mem_wdata", mem_wdata,        32'h0);
      check("reset mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
      check("reset ReadDataM", ReadDataM,        32'h0);
      check("reset FaultM",    {31'h0, FaultM},  32'h0);
      check("reset BusErrM",   {31'h0, BusErrM}, 32'h0);
      check("reset StallM",    {31'h0, StallM},  32'h0);

      for (int i = 0; i < 14; i++) begin
         do_access(vecs[i], st, req, fault, we_o, addr_o, wdata_o, wstrb_o, done_req);
         check($sformatf("vec%0d fault", i),  {31'h0, fault}, {31'h0, vecs[i].e_fault});
         check($sformatf("vec%0d req", i),    {31'h0, req},   {31'h0, vecs[i].e_req});
         check($sformatf("vec%0d stalls", i), 32'(st),        32'(vecs[i].e_stalls));
         check($sformatf("vec%0d ReadDataM", i), ReadDataM,   vecs[i].e_rd);
         if (vecs[i].e_req) begin
            check($sformatf("vec%0d mem_we", i),    {31'h0, we_o},    {31'h0, vecs[i].e_we});
            check($sformatf("vec%0d mem_addr", i),  addr_o,           vecs[i].e_addr);
            check($sformatf("vec%0d mem_wstrb", i), {28'h0, wstrb_o}, {28'h0, vecs[i].e_wstrb});
            check($sformatf("vec%0d done req", i),  {31'h0, done_req}, 32'h0);
            if (vecs[i].e_we)
               check($sformatf("vec%0d mem_wdata", i), wdata_o, vecs[i].e_wdata);
         end
      end

      // Fault is a single-cycle pulse and never raises a request.
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b01;
      Funct3M    = 3'b010;
      ALUResultM = 32'h206;
      #1;
      check("fault stall", {31'h0, StallM}, 32'h0);
      tick();
      clear_inputs();
      check("fault pulse", {31'h0, FaultM}, 32'h1);
      tick();
      check("fault drop", {31'h0, FaultM}, 32'h0);
      check("fault noreq", {31'h0, mem_req}, 32'h0);

      // Reset while BUSY abandons the load; a late ready is ignored.
      ResultSrcM = 2'b01;
      Funct3M    = 3'b010;
      ALUResultM = 32'h10;
      mem_rdata  = 32'hFFFFFFFF;
      tick();
      check("rst seq req", {31'h0, mem_req}, 32'h1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_inputs();
      #1;
      check("rst seq req drop", {31'h0, mem_req}, 32'h0);
      check("rst seq ReadDataM", ReadDataM, 32'h0);
      check("rst seq stall", {31'h0, StallM}, 32'h0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("late ready ReadDataM", ReadDataM, 32'h0);
      check("late ready req", {31'h0, mem_req}, 32'h0);
      check("late ready stall", {31'h0, StallM}, 32'h0);

      // Back in IDLE: a fresh load takes the minimum latency.
      do_access('{1'b0, 2'b01, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 0,
                  1'b0, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0, 2, 32'hCAFEF00D},
                st, req, fault, we_o, addr_o, wdata_o, wstrb_o, done_req);
      check("post rst stalls", 32'(st), 32'd2);
      check("post rst ReadDataM", ReadDataM, 32'hCAFEF00D);

`ifdef LSU_TIMEOUT_EN
      // Never-acknowledged load: 4 BUSY cycles, then DONE with BusErrM and zeroed data.
      ResultSrcM = 2'b01;
      Funct3M    = 3'b010;
      ALUResultM = 32'h40;
      #1;
      st = StallM ? 1 : 0;
      tick();
      for (int i = 0; i < 64 && StallM; i++) begin
         st++;
         tick();
      end
      check("tmo stalls", 32'(st), 32'd5);
      check("tmo BusErrM", {31'h0, BusErrM}, 32'h1);
      check("tmo ReadDataM", ReadDataM, 32'h0);
      check("tmo req drop", {31'h0, mem_req}, 32'h0);
      clear_inputs();
      tick();
      check("tmo BusErrM drop", {31'h0, BusErrM}, 32'h0);
`else
      check("BusErrM tied low", {31'h0, BusErrM}, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
